// File: rtl/decod_scan_nbl_pkg.sv
// rtl/decod_scan_nbl_pkg.sv - shared constants and helpers for the scanning one-hot decoder
package decod_pkg;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Full-width one-hot; callers truncate to their own 1<<SEL_W lines.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        return MAX_OUT_W'(1) << sel;
    endfunction

    // Dwell counter must hold DWELL-1 and never collapse to zero bits.
    function automatic int dcnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/decod_scan_nbl_if.sv
// rtl/decod_scan_nbl_if.sv - control and output bundle of the scanning decoder
interface decod_scan_nbl_if #(
    parameter int SEL_W = 2
);
    localparam int OUT_W = 1 << SEL_W;

    logic             EN;
    logic             MODE;
    logic [SEL_W-1:0] A;
    logic             A_VLD;
    logic [OUT_W-1:0] Y;
    logic [SEL_W-1:0] IDX;
    logic             WRAP;

    modport master (
        output EN, MODE, A, A_VLD,
        input  Y, IDX, WRAP
    );

    modport slave (
        input  EN, MODE, A, A_VLD,
        output Y, IDX, WRAP
    );

endinterface

// File: rtl/decod_scan_nbl_onehot.sv
// rtl/decod_scan_nbl_onehot.sv - combinational SEL_W to 2^SEL_W decoder with enable
module decod_onehot_nbl
    import decod_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int OUT_W = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y = OUT_W'(onehot(MAX_SEL_W'(sel)));
        end
    end

endmodule

// File: rtl/decod_scan_nbl.sv
// rtl/decod_scan_nbl.sv - registered one-hot decoder with direct-load and auto-scan modes
module decod_scan_nbl #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst,
    decod_scan_nbl_if.slave bus
);
    import decod_pkg::*;

    localparam int             DW    = dcnt_width(DWELL);
    localparam logic [DW-1:0]  DLAST = DW'(DWELL - 1);

    logic [SEL_W-1:0] idx;
    logic [DW-1:0]    dcnt;
    logic             en_r;
    logic             mode_r;
    logic             wrap_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            dcnt   <= '0;
            en_r   <= 1'b0;
            mode_r <= MODE_DIRECT;
            wrap_r <= 1'b0;
        end else if (!bus.EN) begin
            // Frozen: dwell progress is kept so scanning resumes in place.
            en_r   <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            en_r   <= 1'b1;
            mode_r <= bus.MODE;
            wrap_r <= 1'b0;
            if (bus.A_VLD) begin
                idx  <= bus.A;
                dcnt <= '0;
            end else if (bus.MODE != mode_r || bus.MODE == MODE_DIRECT) begin
                // A mode change restarts the dwell so the first step is a full DWELL away.
                dcnt <= '0;
            end else if (dcnt == DLAST) begin
                dcnt   <= '0;
                idx    <= idx + 1'b1;
                wrap_r <= (idx == '1);
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    decod_onehot_nbl #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel (idx),
        .en  (en_r),
        .y   (bus.Y)
    );

    assign bus.IDX  = idx;
    assign bus.WRAP = wrap_r;

endmodule

// File: tb/tb_decod_scan_nbl.sv
// tb/tb_decod_scan_nbl.sv - randomized scoreboard bench for three decoder configurations
module tb_decod_scan_nbl;

    typedef struct packed {
        logic [63:0] y;
        logic [5:0]  idx;
        logic        wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, mode, a_vld;
    logic [5:0] a;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decod_scan_nbl_if #(.SEL_W(2)) bus0 ();
    decod_scan_nbl_if #(.SEL_W(1)) bus1 ();
    decod_scan_nbl_if #(.SEL_W(6)) bus2 ();

    assign bus0.EN = en;  assign bus0.MODE = mode;  assign bus0.A_VLD = a_vld;  assign bus0.A = a[1:0];
    assign bus1.EN = en;  assign bus1.MODE = mode;  assign bus1.A_VLD = a_vld;  assign bus1.A = a[0:0];
    assign bus2.EN = en;  assign bus2.MODE = mode;  assign bus2.A_VLD = a_vld;  assign bus2.A = a;

    decod_scan_nbl #(.SEL_W(2), .DWELL(3)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    decod_scan_nbl #(.SEL_W(1), .DWELL(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    decod_scan_nbl #(.SEL_W(6), .DWELL(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    function automatic int cfg_sw(input int c);
        return (c == 0) ? 2 : (c == 1) ? 1 : 6;
    endfunction

    function automatic int cfg_dwell(input int c);
        return (c == 0) ? 3 : (c == 1) ? 1 : 2;
    endfunction

    // Reference: index = start + (enabled scan cycles since last rebase) / DWELL, mod lines.
    int m_start [3];
    int m_el    [3];
    bit m_en    [3];
    bit m_mode  [3];
    bit m_wrap  [3];

    exp_t q0[$], q1[$], q2[$];

    function automatic int m_idx(input int c);
        return (m_start[c] + m_el[c] / cfg_dwell(c)) % (1 << cfg_sw(c));
    endfunction

    task automatic model_edge(input int c);
        int   cur;
        exp_t e;
        if (rst) begin
            m_start[c] = 0; m_el[c] = 0; m_en[c] = 0; m_mode[c] = 0; m_wrap[c] = 0;
        end else if (!en) begin
            m_en[c] = 0; m_wrap[c] = 0;
        end else begin
            cur = m_idx(c);
            m_en[c] = 1; m_wrap[c] = 0;
            if (a_vld) begin
                m_start[c] = int'(a) % (1 << cfg_sw(c)); m_el[c] = 0;
            end else if (mode != m_mode[c] || !mode) begin
                m_start[c] = cur; m_el[c] = 0;
            end else begin
                m_el[c] = m_el[c] + 1;
                if (m_el[c] % cfg_dwell(c) == 0) m_wrap[c] = (m_idx(c) == 0);
            end
            m_mode[c] = mode;
        end
        e.y    = m_en[c] ? (64'd1 << m_idx(c)) : 64'd0;
        e.idx  = 6'(m_idx(c));
        e.wrap = m_wrap[c];
        case (c)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic step(input logic r, input logic e, input logic m, input logic av, input logic [5:0] av_a);
        rst = r; en = e; mode = m; a_vld = av; a = av_a;
        @(posedge clk);
        for (int c = 0; c < 3; c++) model_edge(c);
        #1;
    endtask

    task automatic check(input int c, input logic [63:0] ya, input logic [5:0] ia, input logic wa);
        exp_t e;
        case (c)
            0:       begin if (q0.size() == 0) return; e = q0.pop_front(); end
            1:       begin if (q1.size() == 0) return; e = q1.pop_front(); end
            default: begin if (q2.size() == 0) return; e = q2.pop_front(); end
        endcase
        n_cmp += 3;
        if (ya !== e.y) begin
            n_bad++;
            $display("FAIL cfg%0d Y @%0t: got %h want %h", c, $time, ya, e.y);
        end
        if (ia !== e.idx) begin
            n_bad++;
            $display("FAIL cfg%0d IDX @%0t: got %0d want %0d", c, $time, ia, e.idx);
        end
        if (wa !== e.wrap) begin
            n_bad++;
            $display("FAIL cfg%0d WRAP @%0t: got %b want %b", c, $time, wa, e.wrap);
        end
    endtask

    always @(negedge clk) begin
        check(0, 64'(bus0.Y), 6'(bus0.IDX), bus0.WRAP);
        check(1, 64'(bus1.Y), 6'(bus1.IDX), bus1.WRAP);
        check(2, 64'(bus2.Y), 6'(bus2.IDX), bus2.WRAP);
    end

    initial begin
        logic m_rand;
        rst = 1'b1; en = 1'b0; mode = 1'b0; a_vld = 1'b0; a = '0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        for (int v = 0; v < 4; v++) begin
            step(0, 1, 0, 1, 6'(v));
            step(0, 1, 0, 0, 0);
        end

        step(0, 1, 0, 1, 6'd2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, (i == 2), 6'd1);
        step(0, 1, 0, 0, 0);

        step(0, 1, 0, 1, 6'd0);
        for (int i = 0; i < 13; i++) step(0, 1, 1, 0, 0);

        step(0, 1, 1, 1, 6'd1);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 6'd3);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);

        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);

        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);

        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(0, 1, 0, 1, 6'd0);
        for (int i = 0; i < 300; i++) step(0, 1, 1, 0, 0);

        m_rand = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(29) == 0) m_rand = ~m_rand;
            step(($urandom_range(199) == 0), ($urandom_range(9) != 0), m_rand,
                 ($urandom_range(11) == 0), 6'($urandom));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
